// File: rtl/cr_fifo_wr_arb.sv
// Round-robin write arbiter: N_REQ producers share one FIFO write port, grant held per packet.
// Beats flow combinationally to the FIFO; producers are back-pressured straight from fifo_full.
module cr_fifo_wr_arb #(
    parameter int N_REQ    = 4,
    parameter int DW       = 83,
    parameter int PKT_LOCK = 1,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_last,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  fifo_wen,
    output logic [DW-1:0]         fifo_wdata,
    input  logic                  fifo_full,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    logic            win_found_s;
    logic [IDW-1:0]  win_idx_s;
    logic            g_valid_s;
    logic            g_last_s;
    logic            accept_s;
    logic            pkt_end_s;

    // First valid index after ptr (wrapping); descending scan so the nearest candidate is written last.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [IDW-1:0]   ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            res = valid[idx] ? {1'b1, IDW'(idx)} : res;
        end
        return res;
    endfunction

    // Next-state, grant bookkeeping and the combinational write path.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        stall_cnt_d = stall_cnt_q;
        req_ready   = '0;
        fifo_wen    = 1'b0;
        accept_s    = 1'b0;
        pkt_end_s   = 1'b0;
        {win_found_s, win_idx_s} = rr_pick(req_valid, rr_ptr_q);
        g_valid_s   = req_valid[grant_id_q];
        g_last_s    = req_last[grant_id_q];
        fifo_wdata  = req_data[int'(grant_id_q)*DW +: DW];

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d    = ST_XFER;
                    grant_id_d = win_idx_s;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_XFER: begin
                // rst gating keeps the write port quiet during a mid-packet reset cycle
                req_ready[grant_id_q] = ~fifo_full & ~rst;
                fifo_wen  = g_valid_s & ~fifo_full & ~rst;
                accept_s  = fifo_wen;
                pkt_end_s = accept_s & ((PKT_LOCK == 0) | g_last_s);
                if (pkt_end_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_id_q;
                end else begin
                    state_d  = ST_XFER;
                end
                if (g_valid_s && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end else begin
                    stall_cnt_d = stall_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; rr_ptr starts at the top so producer 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDW'(N_REQ - 1);
            grant_id_q  <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_id  = grant_id_q;
    assign busy      = (state_q == ST_XFER);
    assign stall_cnt = stall_cnt_q;

endmodule
